gaussian_fop_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency floating-point operator core among `NUM_REQ` requesters in the gaussian accelerator. The core is the fadd/fmul style, with an `aclken`, A/B valid/data and a result valid/data. The block grants at most one operand pair per cycle and tags each issue in a shift register that tracks the core pipeline. It routes each result back to its originator, and it back-pressures by gating the core's `aclken` when the addressed requester is not ready.

---
 rtl/gaussian_fop_arbiter.sv | 106 ++++++++++
 tb/tb_gaussian_fop_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_fop_arbiter.sv
// rtl/gaussian_fop_arbiter.sv - round-robin sharing of one fixed-latency FP core among requesters
module gaussian_fop_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int OP_LATENCY = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        s_req_valid,
  output logic [NUM_REQ-1:0]        s_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] s_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] s_req_b,
  output logic [NUM_REQ-1:0]        m_rsp_valid,
  input  logic [NUM_REQ-1:0]        m_rsp_ready,
  output logic [DATA_W-1:0]         m_rsp_data,
  output logic                      core_aclken,
  output logic                      core_a_tvalid,
  output logic                      core_b_tvalid,
  output logic [DATA_W-1:0]         core_a_tdata,
  output logic [DATA_W-1:0]         core_b_tdata,
  input  logic                      core_result_tvalid,
  input  logic [DATA_W-1:0]         core_result_tdata,
  output logic [15:0]               issue_count,
  output logic                      err_tag_mismatch
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [OP_LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]      tag_idx [OP_LATENCY];
  logic [IDX_W-1:0]      rr_ptr;
  logic                  tail_valid;
  logic [IDX_W-1:0]      tail_idx;
  logic [2*NUM_REQ-1:0]  req_rot;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic                  handshake;

  assign tail_valid = tag_valid[OP_LATENCY-1];
  assign tail_idx   = tag_idx[OP_LATENCY-1];
  assign m_rsp_data = core_result_tdata;

  always_comb begin
    m_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_rsp_valid[i] = tail_valid & core_result_tvalid & (tail_idx == IDX_W'(i));
    end
  end

  // Any routed result its owner refuses freezes core, tags and arbiter together.
  assign core_aclken = ~(|(m_rsp_valid & ~m_rsp_ready));

  // Rotate so bit k of req_rot is requester (rr_ptr + k); lowest set bit wins.
  assign req_rot = {s_req_valid, s_req_valid} >> rr_ptr;

  always_comb begin
    int off;
    off   = 0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    winner = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
  end

  assign handshake     = aresetn & found & core_aclken;
  assign core_a_tvalid = handshake;
  assign core_b_tvalid = handshake;

  always_comb begin
    s_req_ready  = '0;
    core_a_tdata = '0;
    core_b_tdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && winner == IDX_W'(i)) begin
        s_req_ready[i] = aresetn & core_aclken;
        core_a_tdata   = s_req_a[i*DATA_W +: DATA_W];
        core_b_tdata   = s_req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_valid        <= '0;
      for (int k = 0; k < OP_LATENCY; k++) tag_idx[k] <= '0;
      rr_ptr           <= '0;
      issue_count      <= '0;
      err_tag_mismatch <= 1'b0;
    end else if (core_aclken) begin
      tag_valid[0] <= handshake;
      tag_idx[0]   <= winner;
      for (int k = 1; k < OP_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
      if (handshake) begin
        rr_ptr      <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        issue_count <= issue_count + 16'd1;
      end
      if (core_result_tvalid != tail_valid) err_tag_mismatch <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gaussian_fop_arbiter.sv
// tb/tb_gaussian_fop_arbiter.sv - randomized self-checking bench for gaussian_fop_arbiter
module tb_gaussian_fop_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   s_req_valid, s_req_ready, m_rsp_valid, m_rsp_ready;
  logic [N*W-1:0] s_req_a, s_req_b;
  logic [W-1:0]   m_rsp_data, core_a_tdata, core_b_tdata, core_result_tdata;
  logic           core_aclken, core_a_tvalid, core_b_tvalid, core_result_tvalid;
  logic [15:0]    issue_count;
  logic           err_tag_mismatch;
  logic           inject, core_clr;

  always #5 aclk = ~aclk;

  gaussian_fop_arbiter #(.NUM_REQ(N), .DATA_W(W), .OP_LATENCY(L)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_a(s_req_a), .s_req_b(s_req_b),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .core_aclken(core_aclken),
    .core_a_tvalid(core_a_tvalid), .core_b_tvalid(core_b_tvalid),
    .core_a_tdata(core_a_tdata), .core_b_tdata(core_b_tdata),
    .core_result_tvalid(core_result_tvalid), .core_result_tdata(core_result_tdata),
    .issue_count(issue_count), .err_tag_mismatch(err_tag_mismatch)
  );

  // Stand-in core: integer adder, L enabled cycles deep, ignores the arbiter reset.
  logic [L-1:0] cp_v;
  logic [W-1:0] cp_d [L];
  always @(posedge aclk) begin
    if (core_clr) begin
      cp_v <= '0;
    end else if (core_aclken) begin
      cp_v[0] <= core_a_tvalid;
      cp_d[0] <= core_a_tdata + core_b_tdata;
      for (int k = 1; k < L; k++) begin
        cp_v[k] <= cp_v[k-1];
        cp_d[k] <= cp_d[k-1];
      end
    end
  end
  assign core_result_tvalid = cp_v[L-1] | inject;
  assign core_result_tdata  = cp_d[L-1];

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    int         age;
  } ent_t;

  ent_t         q[$];
  int           ref_ptr, ref_count;
  logic         ref_err;
  int           n_checks, n_pass, n_fail;
  bit           last_hs;
  int           last_w;
  logic [N-1:0] obs_rv, obs_ready;
  logic         obs_ack, obs_err;
  logic [W-1:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ref_ptr   = 0;
    ref_count = 0;
    ref_err   = 1'b0;
    last_hs   = 1'b0;
  endtask

  // One cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic tick();
    int           w;
    bit           found, tail_v, exp_ack, exp_hs, crv;
    logic [N-1:0] exp_rv, exp_ready;
    logic [W-1:0] exp_a, exp_b;
    @(negedge aclk);
    found = 1'b0;
    w     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (((s_req_valid >> ((ref_ptr + k) % N)) & N'(1)) != '0) begin
        found = 1'b1;
        w     = (ref_ptr + k) % N;
      end
    end
    tail_v    = (q.size() > 0) && (q[0].age == L);
    crv       = core_result_tvalid;
    exp_rv    = (tail_v && crv) ? (N'(1) << q[0].idx) : '0;
    exp_ack   = ((exp_rv & ~m_rsp_ready) == '0);
    exp_hs    = aresetn && found && exp_ack;
    exp_ready = exp_hs ? (N'(1) << w) : '0;
    exp_a     = found ? W'(s_req_a >> (w * W)) : '0;
    exp_b     = found ? W'(s_req_b >> (w * W)) : '0;
    chk("s_req_ready", 64'(s_req_ready), 64'(exp_ready));
    chk("core_aclken", 64'(core_aclken), 64'(exp_ack));
    chk("core_a_tvalid", 64'(core_a_tvalid), 64'(exp_hs));
    chk("core_b_tvalid", 64'(core_b_tvalid), 64'(exp_hs));
    if (aresetn) begin
      chk("core_a_tdata", 64'(core_a_tdata), 64'(exp_a));
      chk("core_b_tdata", 64'(core_b_tdata), 64'(exp_b));
    end
    chk("m_rsp_valid", 64'(m_rsp_valid), 64'(exp_rv));
    if (exp_rv != '0) chk("m_rsp_data", 64'(m_rsp_data), 64'(q[0].data));
    chk("issue_count", 64'(issue_count), 64'(ref_count));
    chk("err_tag_mismatch", 64'(err_tag_mismatch), 64'(ref_err));
    obs_rv    = m_rsp_valid;
    obs_ready = s_req_ready;
    obs_ack   = core_aclken;
    obs_err   = err_tag_mismatch;
    obs_data  = m_rsp_data;
    last_hs   = exp_hs;
    last_w    = w;
    @(posedge aclk);
    if (!aresetn) begin
      model_clear();
    end else if (exp_ack) begin
      if (tail_v != crv) ref_err = 1'b1;
      if (tail_v) void'(q.pop_front());
      foreach (q[k]) q[k].age = q[k].age + 1;
      if (exp_hs) begin
        ent_t e;
        e.idx  = w;
        e.data = exp_a + exp_b;
        e.age  = 1;
        q.push_back(e);
        ref_ptr   = (w + 1) % N;
        ref_count = (ref_count + 1) % 65536;
      end
      last_hs = exp_hs;
    end
    #1;
  endtask

  // Requesters hold operands while waiting; a served one may present new work.
  task automatic drive_reqs(input logic [N-1:0] mask, input bit always_on);
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        s_req_valid[i] = 1'b0;
      end else if (!s_req_valid[i] || (last_hs && last_w == i)) begin
        s_req_valid[i]     = always_on ? 1'b1 : 1'($urandom_range(0, 1));
        s_req_a[i*W +: W]  = $urandom();
        s_req_b[i*W +: W]  = $urandom();
      end
    end
  endtask

  initial begin
    int nstall, held;
    n_checks = 0; n_pass = 0; n_fail = 0;
    inject = 1'b0; core_clr = 1'b1; aresetn = 1'b0;
    s_req_valid = '1; m_rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      s_req_a[i*W +: W] = $urandom();
      s_req_b[i*W +: W] = $urandom();
    end
    model_clear();
    #2;
    repeat (3) tick();
    core_clr = 1'b0;
    aresetn  = 1'b1;

    // single request from requester 2
    s_req_valid = 4'b0100;
    s_req_a[2*W +: W] = 32'h3F80_0000;
    s_req_b[2*W +: W] = 32'h4000_0000;
    tick();
    chk("single_grant", 64'(obs_ready), 64'(4'b0100));
    s_req_valid = '0;
    tick();
    tick();
    chk("single_rsp_valid", 64'(obs_rv), 64'(4'b0100));
    chk("single_rsp_data", 64'(obs_data), 64'(32'h7F80_0000));
    chk("single_issue_count", 64'(issue_count), 64'd1);

    // fairness: everyone always valid; pointer starts just past requester 2
    drive_reqs(4'hF, 1'b1);
    for (int g = 0; g < 100; g++) begin
      tick();
      chk("fair_grant", 64'(obs_ready), 64'(4'b0001 << ((3 + g) % 4)));
      drive_reqs(4'hF, 1'b1);
    end
    chk("fair_issue_count", 64'(issue_count), 64'd101);
    s_req_valid = '0;
    repeat (L + 1) tick();

    // back-pressure: requester 1 refuses its result for three cycles
    nstall = 0; held = 0;
    drive_reqs(4'b0011, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (c >= 4 && held < 3 && q.size() > 0 && q[0].age == L && q[0].idx == 1) begin
        m_rsp_ready = 4'b1101;
        held++;
      end else begin
        m_rsp_ready = 4'b1111;
      end
      tick();
      if (!obs_ack) nstall++;
      drive_reqs(4'b0011, 1'b1);
    end
    chk("bp_stall_cycles", 64'(nstall), 64'd3);
    s_req_valid = '0;
    repeat (L + 1) tick();

    // wrap/skip: park pointer at 3, then only 1 and 3 request
    s_req_valid = 4'b0100;
    tick();
    s_req_valid = '0;
    drive_reqs(4'b1010, 1'b1);
    tick();
    chk("wrap_g0", 64'(obs_ready), 64'(4'b1000));
    drive_reqs(4'b1010, 1'b1);
    tick();
    chk("wrap_g1", 64'(obs_ready), 64'(4'b0010));
    drive_reqs(4'b1010, 1'b1);
    tick();
    chk("wrap_g2", 64'(obs_ready), 64'(4'b1000));
    s_req_valid = '0;
    repeat (L + 1) tick();

    // randomized traffic with random result back-pressure
    for (int c = 0; c < 300; c++) begin
      drive_reqs(4'hF, 1'b0);
      for (int i = 0; i < N; i++) m_rsp_ready[i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_req_valid = '0; m_rsp_ready = '1;
    repeat (L + 2) tick();

    // spurious core result with an empty tail
    inject = 1'b1;
    tick();
    chk("mm_rsp_valid", 64'(obs_rv), 64'd0);
    inject = 1'b0;
    tick();
    chk("mm_err_set", 64'(obs_err), 64'd1);
    repeat (5) tick();
    chk("mm_err_sticky", 64'(obs_err), 64'd1);

    // reset with two tags in flight
    s_req_valid = 4'b0001;
    tick();
    last_hs = 1'b0;
    s_req_valid = 4'b0010;
    tick();
    s_req_valid = 4'b1000;
    #1;
    aresetn = 1'b0;
    #1;
    chk("rst_s_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst_m_rsp_valid", 64'(m_rsp_valid), 64'd0);
    chk("rst_core_aclken", 64'(core_aclken), 64'd1);
    chk("rst_core_tvalid", 64'({core_a_tvalid, core_b_tvalid}), 64'd0);
    chk("rst_issue_count", 64'(issue_count), 64'd0);
    chk("rst_err", 64'(err_tag_mismatch), 64'd0);
    model_clear();
    tick();
    aresetn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      drive_reqs(4'hF, 1'b0);
      for (int i = 0; i < N; i++) m_rsp_ready[i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("post_rst_err_from_stale", 64'(err_tag_mismatch), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
